// File: rtl/inst_prefetch_buffer_if.sv
// Signal bundle between the prefetch buffer, the AXI instruction channel and the CPU fetch stage.
// CPU side handshake: one entry moves on every aclk edge where cpu_valid_o and cpu_ready_i are
// both high. cpu_valid_o never depends on cpu_ready_i. The head entry stays stable until it is
// taken or a redirect clears the queue. On the AXI side, req_en_o/req_pc_o stay asserted and
// stable until the single-cycle inst_valid_i pulse returns.
interface inst_prefetch_buffer_if;
  logic [31:0] req_pc_o;
  logic        req_en_o;
  logic        axi_flush_o;
  logic [31:0] inst_i;
  logic        inst_valid_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        cpu_valid_o;
  logic [31:0] cpu_pc_o;
  logic [31:0] cpu_inst_o;
  logic        cpu_ready_i;

  // The prefetch buffer itself.
  modport master (
    output req_pc_o, req_en_o, axi_flush_o, cpu_valid_o, cpu_pc_o, cpu_inst_o,
    input  inst_i, inst_valid_i, redirect_i, redirect_pc_i, cpu_ready_i
  );

  // The surrounding AXI interface and CPU.
  modport slave (
    input  req_pc_o, req_en_o, axi_flush_o, cpu_valid_o, cpu_pc_o, cpu_inst_o,
    output inst_i, inst_valid_i, redirect_i, redirect_pc_i, cpu_ready_i
  );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential fetches, queues {pc, inst} pairs in a small FIFO
// and serves them to the CPU. A redirect empties the queue and drops a stale in-flight response.
module inst_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  inst_prefetch_buffer_if.master        bus,
  output logic [1:0]                    o_dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic          w_push;
  logic          w_pop;
  logic          w_space;
  logic          w_not_empty;

  // Push/pop qualification and occupancy after this cycle; a redirect suppresses both.
  always_comb begin
    w_not_empty  = (r_count != '0);
    w_push       = (r_state == REQ) && bus.inst_valid_i && !bus.redirect_i;
    w_pop        = w_not_empty && bus.cpu_ready_i && !bus.redirect_i;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_space      = (w_count_next < DEPTH_C);
  end

  // Next-state and next fetch PC; redirect outranks every other event in the cycle.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    if (bus.redirect_i) begin
      w_fetch_pc_next = bus.redirect_pc_i;
      // A request still outstanding at the AXI side must have its response swallowed.
      if ((r_state == REQ || r_state == DROP) && !bus.inst_valid_i) begin
        w_state_next = DROP;
      end else begin
        w_state_next = IDLE;
      end
    end else begin
      case (r_state)
        IDLE: begin
          // Space is reserved before issuing, so a returned response always fits.
          if (w_space) w_state_next = REQ;
        end
        REQ: begin
          if (bus.inst_valid_i) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
            w_state_next    = w_space ? REQ : IDLE;
          end
        end
        DROP: begin
          if (bus.inst_valid_i) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State and fetch PC registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
    end
  end

  // Store a returned instruction with the PC it was fetched from.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
      r_inst_mem[r_wr_ptr] <= bus.inst_i;
    end
  end

  assign bus.req_en_o    = (r_state == REQ);
  assign bus.req_pc_o    = r_fetch_pc;
  assign bus.axi_flush_o = bus.redirect_i & aresetn;
  assign bus.cpu_valid_o = w_not_empty;
  // Head is forced to zero while empty so the outputs are deterministic.
  assign bus.cpu_pc_o    = w_not_empty ? r_pc_mem[r_rd_ptr]   : 32'd0;
  assign bus.cpu_inst_o  = w_not_empty ? r_inst_mem[r_rd_ptr] : 32'd0;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Bench for inst_prefetch_buffer: an AXI responder, a randomized CPU/redirect driver, and a
// monitor popping an expected {pc, inst} queue whenever the CPU takes an entry.
module tb_inst_prefetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam int          W        = 64;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [1:0] dbg_state;

  inst_prefetch_buffer_if bus ();

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- shared state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int          cyc = 0;
  bit          rsp_busy = 0;
  bit          rsp_stale = 0;
  int          rsp_wait = 0;
  logic [31:0] rsp_pc = '0;
  logic [31:0] exp_req_pc = RESET_PC;
  int          due_req = -1;
  int          due_b2b = -1;
  bit          prev_redir = 0;
  int          lat_lo = 0;
  int          lat_hi = 0;
  int          redir_pm = 0;
  bit          redir_on_pulse = 0;
  logic [31:0] redir_target = '0;
  int          pushes = 0;
  int          reqs = 0;
  int          delivered = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5EED_C0DE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.inst_i        = '0;
    bus.inst_valid_i  = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.cpu_ready_i   = 1'b0;
  endtask

  // Assert reset at the current negedge, hold for n edges, check reset outputs, release.
  task automatic do_reset(input int n);
    aresetn = 1'b0;
    drive_idle();
    rsp_busy = 0; rsp_stale = 0; exp_q.delete(); exp_req_pc = RESET_PC;
    due_req = -1; due_b2b = -1; prev_redir = 0;
    repeat (n) @(negedge aclk);
    chk("rst_req_en",    32'(bus.req_en_o),    32'd0);
    chk("rst_flush",     32'(bus.axi_flush_o), 32'd0);
    chk("rst_cpu_valid", 32'(bus.cpu_valid_o), 32'd0);
    chk("rst_req_pc",    bus.req_pc_o,         RESET_PC);
    chk("rst_cpu_pc",    bus.cpu_pc_o,         32'd0);
    chk("rst_cpu_inst",  bus.cpu_inst_o,       32'd0);
    aresetn = 1'b1;
  endtask

  // One clock of AXI responder, CPU ready and redirect driving, plus the reference model update.
  task automatic step(input int ready_pct, input bit force_redir, input logic [31:0] force_pc);
    bit          pulse;
    bit          redir;
    bit          on_pulse;
    bit          pop_now;
    logic [31:0] rpc;
    @(negedge aclk);
    cyc++;
    if (due_req == cyc) begin
      chk("req_latency_en", 32'(bus.req_en_o), 32'd1);
      chk("req_latency_pc", bus.req_pc_o, exp_req_pc);
      due_req = -1;
    end else if (due_req == cyc + 1) begin
      chk("req_idle_gap", 32'(bus.req_en_o), 32'd0);
    end
    if (due_b2b == cyc) begin
      chk("back_to_back_en", 32'(bus.req_en_o), 32'd1);
      due_b2b = -1;
    end
    if (prev_redir) chk("valid_after_redirect", 32'(bus.cpu_valid_o), 32'd0);

    if (!rsp_busy) begin
      if (bus.req_en_o) begin
        chk("req_pc", bus.req_pc_o, exp_req_pc);
        rsp_busy  = 1;
        rsp_stale = 0;
        rsp_pc    = bus.req_pc_o;
        rsp_wait  = $urandom_range(lat_hi, lat_lo);
        reqs++;
      end
    end else if (!rsp_stale) begin
      chk("req_hold_en", 32'(bus.req_en_o), 32'd1);
      chk("req_hold_pc", bus.req_pc_o, rsp_pc);
    end else begin
      chk("drop_req_en", 32'(bus.req_en_o), 32'd0);
    end

    pulse = rsp_busy && (rsp_wait == 0);
    if (rsp_busy && !pulse) rsp_wait--;
    on_pulse = redir_on_pulse && pulse && !rsp_stale;
    redir = force_redir || on_pulse ||
            (!(rsp_stale && pulse) && ($urandom_range(999, 0) < redir_pm));
    if (force_redir)   rpc = force_pc;
    else if (on_pulse) rpc = redir_target;
    else               rpc = $urandom() & 32'hFFFF_FFFC;
    if (on_pulse) redir_on_pulse = 0;

    bus.inst_valid_i  = pulse;
    bus.inst_i        = pulse ? inst_of(rsp_pc) : 32'($urandom());
    bus.cpu_ready_i   = ($urandom_range(99, 0) < ready_pct);
    bus.redirect_i    = redir;
    bus.redirect_pc_i = redir ? rpc : 32'($urandom());
    pop_now = bus.cpu_valid_o && bus.cpu_ready_i && !redir;

    if (redir) begin
      exp_q.delete();
      exp_req_pc = rpc;
      pushes = 0;
      reqs = 0;
      due_b2b = -1;
      if (rsp_busy && !pulse) begin
        rsp_stale = 1;
      end else begin
        rsp_busy = 0; rsp_stale = 0;
        due_req = cyc + 2;
      end
    end else if (pulse) begin
      if (rsp_stale) begin
        due_req = cyc + 2;
      end else begin
        exp_q.push_back({rsp_pc, inst_of(rsp_pc)});
        exp_req_pc = rsp_pc + 32'd4;
        pushes++;
        if (exp_q.size() - int'(pop_now) < DEPTH) due_b2b = cyc + 1;
      end
      rsp_busy = 0; rsp_stale = 0;
    end
    prev_redir = redir;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge aclk);
      #1;
      if (!aresetn) continue;
      chk("axi_flush", 32'(bus.axi_flush_o), 32'(bus.redirect_i));
      if (bus.cpu_valid_o && bus.cpu_ready_i && !bus.redirect_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry actual pc=%h inst=%h required none (cycle %0d)",
                   bus.cpu_pc_o, bus.cpu_inst_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_pc",   bus.cpu_pc_o,   e[63:32]);
          chk("cpu_inst", bus.cpu_inst_o, e[31:0]);
          delivered++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    drive_idle();
    do_reset(3);

    // Sequential fetch with fixed 2-cycle response, CPU always ready.
    lat_lo = 2; lat_hi = 2; redir_pm = 0;
    repeat (20) step(100, 0, '0);

    // Stall: queue fills to DEPTH, no further requests; one pop frees exactly one slot.
    lat_lo = 1; lat_hi = 1;
    step(0, 1, 32'h0040_0000);
    repeat (25) step(0, 0, '0);
    chk("stall_pushes", 32'(pushes), 32'(DEPTH));
    chk("stall_req_en", 32'(bus.req_en_o), 32'd0);
    chk("stall_valid",  32'(bus.cpu_valid_o), 32'd1);
    step(100, 0, '0);
    repeat (10) step(0, 0, '0);
    chk("one_pop_pushes", 32'(pushes), 32'(DEPTH + 1));
    chk("one_pop_reqs",   32'(reqs),   32'(DEPTH + 1));
    repeat (15) step(100, 0, '0);

    // Redirect while a request is outstanding: late response must be dropped.
    lat_lo = 3; lat_hi = 3;
    n = 0;
    while (!(rsp_busy && !rsp_stale && rsp_wait >= 1) && n < 50) begin
      step(100, 0, '0);
      n++;
    end
    chk("find_req_timeout", 32'(n < 50), 32'd1);
    step(100, 1, 32'h8000_1000);
    repeat (20) step(100, 0, '0);

    // Redirect in the same cycle as a response: no DROP, new request two cycles later.
    lat_lo = 2; lat_hi = 2;
    redir_target = 32'h0000_1000;
    redir_on_pulse = 1;
    n = 0;
    while (redir_on_pulse && n < 50) begin
      step(100, 0, '0);
      n++;
    end
    chk("pulse_redirect_timeout", 32'(n < 50), 32'd1);
    repeat (10) step(100, 0, '0);

    // Steady push+pop at DEPTH-1 occupancy, many pointer wraps.
    lat_lo = 0; lat_hi = 0;
    repeat (15) step(0, 0, '0);
    step(100, 0, '0);
    repeat (20) begin
      step(100, 0, '0);
      chk("steady_req_en", 32'(bus.req_en_o),    32'd1);
      chk("steady_valid",  32'(bus.cpu_valid_o), 32'd1);
    end

    // PC wrap after redirect to the top word, then reset during REQ.
    lat_lo = 1; lat_hi = 1;
    step(100, 1, 32'hFFFF_FFFC);
    repeat (12) step(100, 0, '0);
    n = 0;
    while (!bus.req_en_o && n < 20) begin
      step(100, 0, '0);
      n++;
    end
    chk("find_req_for_reset", 32'(bus.req_en_o), 32'd1);
    do_reset(1);
    repeat (10) step(100, 0, '0);

    // Randomized traffic with random latency, ready and redirects.
    lat_lo = 0; lat_hi = 3; redir_pm = 25;
    repeat (1500) step(60, 0, '0);

    // Drain.
    redir_pm = 0;
    repeat (40) step(100, 0, '0);
    chk("delivered_some", 32'(delivered > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
